// File: rtl/psimd_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : psimd_issue_ctrl
//  Purpose  : Issue/sequencing controller for the PSIMD DLFloat datapath.
//             It contains an instruction FIFO with a valid/ready handshake,
//             a per-register pending-write scoreboard that enforces RAW
//             ordering against a fixed-latency execution pipe, writeback
//             tracking, and sticky per-lane IEEE exception flags.
//  Optional : PSIMD_WB_BYPASS_EN. When defined, a source whose last pending
//             write is being written back this cycle does not stall issue.
//  Ports    : clk, rst (sync, active-high)
//             instr_valid/instr/instr_ready     upstream handshake
//             issue_valid/issue_instr/issue_ready  downstream issue
//             wb_valid/wb_rd                    writeback of writing ops
//             eu_* [LANES]                      EU flags, sampled on wb_valid
//             flag_clr, invalid..div_by_zero    sticky flag clear/outputs
//             fifo_count                        FIFO occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module psimd_issue_ctrl #(
    parameter int LANES  = 4,
    parameter int DEPTH  = 4,
    parameter int EU_LAT = 3,
    parameter int NREG   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       instr_valid,
    input  logic [31:0]                instr,
    output logic                       instr_ready,
    output logic                       issue_valid,
    output logic [31:0]                issue_instr,
    input  logic                       issue_ready,
    output logic                       wb_valid,
    output logic [4:0]                 wb_rd,
    input  logic [LANES-1:0]           eu_invalid,
    input  logic [LANES-1:0]           eu_inexact,
    input  logic [LANES-1:0]           eu_overflow,
    input  logic [LANES-1:0]           eu_underflow,
    input  logic [LANES-1:0]           eu_div_by_zero,
    input  logic                       flag_clr,
    output logic [LANES-1:0]           invalid,
    output logic [LANES-1:0]           inexact,
    output logic [LANES-1:0]           overflow,
    output logic [LANES-1:0]           underflow,
    output logic [LANES-1:0]           div_by_zero,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_PEND_W = $clog2(EU_LAT + 1);
`ifdef PSIMD_WB_BYPASS_EN
    localparam bit c_BYPASS = 1'b1;
`else
    localparam bit c_BYPASS = 1'b0;
`endif

    // ---------------- FIFO ----------------
    logic [31:0]          r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic [31:0]          w_head;

    assign w_full = (r_count == c_CNT_W'(DEPTH));
    assign w_push = instr_valid && !w_full;
    assign w_pop  = issue_valid;
    assign w_head = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= instr;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // ---------------- Head decode ----------------
    logic [4:0] w_rd, w_rs1, w_rs2, w_rs3;
    logic       w_writes;
    logic       w_use_rs3;

    assign w_rd      = w_head[11:7];
    assign w_rs1     = w_head[19:15];
    assign w_rs2     = w_head[24:20];
    assign w_rs3     = w_head[31:27];
    assign w_writes  = (w_head[6:0] != 7'b0100111);
    assign w_use_rs3 = (w_head[6:4] == 3'b100);

    // ---------------- In-flight pipe ----------------
    logic [EU_LAT-1:0] r_pipe_v;
    logic [4:0]        r_pipe_rd [EU_LAT];
    logic              w_wb_valid;
    logic [4:0]        w_wb_rd;
    logic              w_issue_wr;

    assign w_wb_valid = r_pipe_v[EU_LAT-1];
    assign w_wb_rd    = r_pipe_rd[EU_LAT-1];
    assign w_issue_wr = issue_valid && w_writes;

    // The pipe never stalls: issue_ready only gates new entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < EU_LAT; i++) begin
                r_pipe_v[i]  <= 1'b0;
                r_pipe_rd[i] <= '0;
            end
        end else begin
            r_pipe_v[0]  <= w_issue_wr;
            r_pipe_rd[0] <= w_issue_wr ? w_rd : 5'd0;
            for (int i = 1; i < EU_LAT; i++) begin
                r_pipe_v[i]  <= r_pipe_v[i-1];
                r_pipe_rd[i] <= r_pipe_rd[i-1];
            end
        end
    end

    // ---------------- Scoreboard ----------------
    // A counter per register tracks outstanding writers so that WAW issue
    // keeps the register busy until the last writer retires. An issue and a
    // writeback to the same register in one cycle cancel, so the newer
    // writer keeps the register busy.
    logic [c_PEND_W-1:0] r_pend [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_pend[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if ((w_issue_wr && w_rd == 5'(r)) && !(w_wb_valid && w_wb_rd == 5'(r))) begin
                    r_pend[r] <= r_pend[r] + 1'b1;
                end else if (!(w_issue_wr && w_rd == 5'(r)) && (w_wb_valid && w_wb_rd == 5'(r))) begin
                    r_pend[r] <= r_pend[r] - 1'b1;
                end
            end
        end
    end

    function automatic logic f_blocked(input logic [4:0] reg_id);
        logic retiring;
        retiring  = c_BYPASS && (r_pend[reg_id] == c_PEND_W'(1))
                    && w_wb_valid && (w_wb_rd == reg_id);
        f_blocked = (r_pend[reg_id] != '0) && !retiring;
    endfunction

    logic w_hazard;
    always_comb begin
        w_hazard = f_blocked(w_rs1) || f_blocked(w_rs2);
        if (w_use_rs3 && f_blocked(w_rs3)) begin
            w_hazard = 1'b1;
        end
    end

    assign instr_ready = !w_full;
    assign issue_valid = (r_count != '0) && issue_ready && !w_hazard;
    assign issue_instr = issue_valid ? w_head : 32'd0;
    assign wb_valid    = w_wb_valid;
    assign wb_rd       = w_wb_valid ? w_wb_rd : 5'd0;
    assign fifo_count  = r_count;

    // ---------------- Sticky flags ----------------
    // Clear applies to the old value only; same-cycle new bits survive.
    logic [LANES-1:0] r_invalid, r_inexact, r_overflow, r_underflow, r_div_by_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_invalid     <= '0;
            r_inexact     <= '0;
            r_overflow    <= '0;
            r_underflow   <= '0;
            r_div_by_zero <= '0;
        end else begin
            r_invalid     <= (flag_clr ? '0 : r_invalid)     | (w_wb_valid ? eu_invalid     : '0);
            r_inexact     <= (flag_clr ? '0 : r_inexact)     | (w_wb_valid ? eu_inexact     : '0);
            r_overflow    <= (flag_clr ? '0 : r_overflow)    | (w_wb_valid ? eu_overflow    : '0);
            r_underflow   <= (flag_clr ? '0 : r_underflow)   | (w_wb_valid ? eu_underflow   : '0);
            r_div_by_zero <= (flag_clr ? '0 : r_div_by_zero) | (w_wb_valid ? eu_div_by_zero : '0);
        end
    end

    assign invalid     = r_invalid;
    assign inexact     = r_inexact;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_psimd_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_psimd_issue_ctrl
//  Purpose  : Self-checking bench for psimd_issue_ctrl. A timestamp-based
//             reference model (queue of words, last-writer issue cycle per
//             register, list of scheduled writebacks) predicts every output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_psimd_issue_ctrl;

    localparam int LANES  = 4;
    localparam int DEPTH  = 4;
    localparam int EU_LAT = 3;
    localparam int NREG   = 32;
`ifdef PSIMD_WB_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             instr_valid;
    logic [31:0]      instr;
    logic             instr_ready;
    logic             issue_valid;
    logic [31:0]      issue_instr;
    logic             issue_ready;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [LANES-1:0] eu_f [5];
    logic             flag_clr;
    logic [LANES-1:0] fl_out [5];
    logic [$clog2(DEPTH):0] fifo_count;

    always #5 clk = ~clk;

    psimd_issue_ctrl #(.LANES(LANES), .DEPTH(DEPTH), .EU_LAT(EU_LAT), .NREG(NREG)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .eu_invalid(eu_f[0]), .eu_inexact(eu_f[1]), .eu_overflow(eu_f[2]),
        .eu_underflow(eu_f[3]), .eu_div_by_zero(eu_f[4]),
        .flag_clr(flag_clr),
        .invalid(fl_out[0]), .inexact(fl_out[1]), .overflow(fl_out[2]),
        .underflow(fl_out[3]), .div_by_zero(fl_out[4]),
        .fifo_count(fifo_count)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // ---------------- reference model state ----------------
    int               cyc;
    logic [31:0]      q[$];
    int               last_wr [NREG];
    int               wb_cyc[$];
    logic [4:0]       wb_rdq[$];
    logic [LANES-1:0] m_flag [5];

    function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1,
                                       input int rs2, input int rs3);
        return {5'(rs3), 2'b00, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), op};
    endfunction

    localparam logic [6:0] OP_ALU = 7'b1010011;
    localparam logic [6:0] OP_R4  = 7'b1000011;
    localparam logic [6:0] OP_ST  = 7'b0100111;

    function automatic bit reg_free(input logic [4:0] r);
        return cyc >= last_wr[r] + EU_LAT + 1 - BYP;
    endfunction

    function automatic bit wb_now();
        return wb_cyc.size() > 0 && wb_cyc[0] == cyc;
    endfunction

    task automatic model_reset();
        q.delete();
        wb_cyc.delete();
        wb_rdq.delete();
        for (int r = 0; r < NREG; r++) last_wr[r] = -1000;
        for (int k = 0; k < 5; k++) m_flag[k] = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: inputs were driven by the caller; check, then advance.
    task automatic cycle();
        bit          e_rdy, e_iss, e_wb;
        logic [31:0] h;
        logic [4:0]  e_wbrd;
        #3;
        e_rdy = q.size() < DEPTH;
        e_iss = 1'b0;
        h     = '0;
        if (q.size() > 0 && issue_ready) begin
            h = q[0];
            e_iss = reg_free(h[19:15]) && reg_free(h[24:20]) &&
                    (h[6:4] != 3'b100 || reg_free(h[31:27]));
        end
        e_wb   = wb_now();
        e_wbrd = e_wb ? wb_rdq[0] : 5'd0;
        check("instr_ready", 32'(instr_ready), 32'(e_rdy));
        check("fifo_count",  32'(fifo_count),  32'(q.size()));
        check("issue_valid", 32'(issue_valid), 32'(e_iss));
        check("issue_instr", issue_instr,      e_iss ? h : 32'd0);
        check("wb_valid",    32'(wb_valid),    32'(e_wb));
        check("wb_rd",       32'(wb_rd),       32'(e_wbrd));
        for (int k = 0; k < 5; k++) check("sticky_flag", 32'(fl_out[k]), 32'(m_flag[k]));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (e_wb) begin
                void'(wb_cyc.pop_front());
                void'(wb_rdq.pop_front());
            end
            for (int k = 0; k < 5; k++)
                m_flag[k] = (flag_clr ? '0 : m_flag[k]) | (e_wb ? eu_f[k] : '0);
            if (e_iss) begin
                void'(q.pop_front());
                if (h[6:0] != OP_ST) begin
                    last_wr[h[11:7]] = cyc;
                    wb_cyc.push_back(cyc + EU_LAT);
                    wb_rdq.push_back(h[11:7]);
                end
            end
            if (instr_valid && e_rdy) q.push_back(instr);
        end
        cyc++;
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        instr_valid = 1'b1;
        instr = w;
        cycle();
        instr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic rand_instr();
        int sel;
        sel = $urandom_range(0, 2);
        instr = mk(sel == 0 ? OP_ST : (sel == 1 ? OP_R4 : OP_ALU),
                   $urandom_range(0, 5), $urandom_range(0, 5),
                   $urandom_range(0, 5), $urandom_range(0, 5));
    endtask

    initial begin
        cyc = 0;
        model_reset();
        rst = 1'b1; instr_valid = 1'b0; instr = '0; issue_ready = 1'b1; flag_clr = 1'b0;
        for (int k = 0; k < 5; k++) eu_f[k] = '0;
        @(posedge clk); #1;
        idle(1);
        rst = 1'b0;
        idle(1);

        // Independent back-to-back ops
        push(mk(OP_ALU, 1, 10, 10, 0));
        push(mk(OP_ALU, 2, 11, 11, 0));
        push(mk(OP_ALU, 3, 12, 12, 0));
        idle(6);

        // RAW dependency
        push(mk(OP_ALU, 5, 10, 11, 0));
        push(mk(OP_ALU, 6, 5, 12, 0));
        idle(8);

        // Fill with issue stalled, then drain with wrap-around
        issue_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(mk(OP_ALU, 8 + i, 20, 21, 0));
        instr_valid = 1'b1;
        idle(2);
        issue_ready = 1'b1;
        for (int i = 0; i < 10; i++) push(mk(OP_ST, 13 + i, 20, 21, 0));
        idle(6);

        // Sticky flags: overflow 0010, then 1000 with clear in the same cycle
        push(mk(OP_ALU, 9, 20, 21, 0));
        eu_f[2] = 4'b0010;
        while (!wb_now()) cycle();
        cycle();
        eu_f[2] = '0;
        push(mk(OP_ALU, 10, 20, 21, 0));
        while (!wb_now()) cycle();
        eu_f[2] = 4'b1000; flag_clr = 1'b1;
        cycle();
        eu_f[2] = '0; flag_clr = 1'b0;
        idle(2);

        // Reset while writes are in flight and the FIFO holds entries
        push(mk(OP_ALU, 14, 20, 21, 0));
        push(mk(OP_ALU, 15, 20, 21, 0));
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(mk(OP_ALU, 16, 14, 15, 0));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        issue_ready = 1'b1;
        push(mk(OP_R4, 17, 14, 15, 15));
        idle(6);

        // WAW to r7 followed by a reader of rs2=7
        push(mk(OP_ALU, 7, 20, 21, 0));
        push(mk(OP_ALU, 7, 20, 21, 0));
        push(mk(OP_ALU, 18, 22, 7, 0));
        idle(8);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            instr_valid = ($urandom_range(0, 3) != 0);
            rand_instr();
            issue_ready = ($urandom_range(0, 4) != 0);
            flag_clr    = ($urandom_range(0, 7) == 0);
            rst         = ($urandom_range(0, 96) == 0);
            for (int k = 0; k < 5; k++) eu_f[k] = LANES'($urandom);
            cycle();
        end
        rst = 1'b0; instr_valid = 1'b0; issue_ready = 1'b1;
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
